train_scheduler: RTL and testbench
==================================

# train_scheduler

Epoch sequencer for the NeuralNet training datapath. It issues one request per sample: `n_train` training samples with weight update enabled, then `n_valid` validation samples with update disabled. It accumulates validation error per epoch, pulses `save` when validation error improves, and stops on max epoch, early-stop patience or abort. It sits between the host configuration and the shared forward/backprop datapath, which it owns exclusively while `busy`.

## Interface
- `BITS`, 16: width of counts, indices and per-sample error.
- `ACC`, 32: width of the validation error accumulator; must be at least `BITS`.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin a run; sampled only in IDLE.
- `abort` in 1: terminate the run; sampled only while busy.
- `n_train` in BITS: training samples per epoch; latched at start.
- `n_valid` in BITS: validation samples per epoch; latched at start.
- `max_epoch` in BITS: epoch limit; latched at start.
- `patience` in BITS: non-improving epochs before early stop; 0 disables early stop; latched at start.
- `req` out 1: one-cycle request to the datapath to process sample `sample_idx`.
- `train_mode` out 1: 1 = training sample (backprop on), 0 = validation sample; valid with `req`.
- `sample_idx` out BITS: 0-based index within the current phase.
- `epoch` out BITS: 0-based current epoch.
- `done_in` in 1: datapath completion pulse.
- `sample_err` in BITS: unsigned sample error; valid with `done_in`.
- `save` out 1: one-cycle pulse meaning "current weights are best so far".
- `busy` out 1: run in progress.
- `done` out 1: one-cycle end-of-run pulse.
- `stop_reason` out 2: cause of the last stop. 00 = none, 01 = max_epoch, 10 = early stop, 11 = abort. Held until the next accepted start.

## Operation
- States: IDLE, T_REQ, T_WAIT, V_REQ, V_WAIT, EVAL, DONE.
- IDLE, on `start`:
  - Latch the config, clear `epoch`, `sample_idx`, `stall` and the accumulator; clear `stop_reason`.
  - If `max_epoch==0`, go to DONE with reason 01 and issue no requests.
  - Else go to T_REQ, or to V_REQ if `n_train==0`, or to EVAL if both counts are 0.
- T_REQ: `req=1`, `train_mode=1` for one cycle, then T_WAIT.
- T_WAIT, on `done_in`:
  - Increment `sample_idx`.
  - If `sample_idx==n_train-1`, clear it and go to V_REQ, or to EVAL if `n_valid==0`.
  - Otherwise go to T_REQ.
  - `sample_err` is ignored in this phase.
- V_REQ / V_WAIT: same as the training phase with `train_mode=0`.
  - On `done_in`, add `sample_err` to the accumulator, saturating at 2^ACC-1.
  - The last sample goes to EVAL.
- EVAL (one cycle):
  - If `epoch==0` or `acc < best`: set `best<=acc`, `stall<=0`, `save` pulses.
  - Else `stall<=stall+1`. Equal error counts as not improved.
  - Then clear `acc`.
  - If `patience!=0` and the new stall equals `patience`: go to DONE, reason 10.
  - Else if `epoch+1==max_epoch`: go to DONE, reason 01.
  - Else increment `epoch` and start the next epoch using the same entry rule as start.
- DONE: `done=1` for one cycle, `busy=0`, then IDLE.
- `abort` while busy, from any state:
  - Next state is DONE with reason 11; no `save`.
  - A `done_in` in the same cycle is discarded and not accumulated.
  - A late `done_in` after the abort is ignored.
- `done_in` outside T_WAIT/V_WAIT is ignored.
- `start` while busy is ignored.
- The `epoch` counter does not wrap: `max_epoch ≤ 2^BITS-1` bounds it.

## Timing
- Reset values: `req`, `train_mode`, `save`, `busy`, `done` = 0; `sample_idx`, `epoch` = 0; `stop_reason` = 00. Internal state is IDLE and `best` is all ones.
- All outputs are registered; no combinational input-to-output path.
- `start` at cycle 0:
  - `busy=1` and the first `req=1` at cycle 1.
  - `done_in` at cycle k gives the next `req` at cycle k+1.
  - Minimum 2 cycles per sample.
- Last validation `done_in` at cycle k: EVAL at cycle k+1, `save` at cycle k+2. In the same cycle k+2 comes either the next `req` or `done`.
- `abort` at cycle k: `done=1` and `busy=1` at cycle k+1; `busy=0` and IDLE at cycle k+2.
- `rst_n` low mid-run: immediate return to the reset values. No `done` or `save` is emitted.

## Test plan
- Normal run: `n_train=10`, `n_valid=10`, `max_epoch=2`, `patience=0`; datapath answers each `req` 3 cycles later with `sample_err=2`.
  - Required: 40 `req` pulses total, with `train_mode` pattern 10×1 then 10×0 per epoch.
  - `save` pulses only after epoch 0, since epoch 1 sum is equal at 20.
  - `done` with `stop_reason=01`.
- Improving error: same config, epoch 1 errors 1 each.
  - Required: `save` pulses after both epochs.
- Early stop: `max_epoch=10`, `patience=2`, constant error.
  - Required: `save` once; `done` with reason 10 after epoch 2; `epoch` never exceeds 2.
- Abort mid-wait: assert `abort` in T_WAIT of epoch 0, together with `done_in`.
  - Required: `done` on the next cycle with reason 11; no further `req`.
  - A later `done_in` is ignored; a new `start` works.
- Edge configs:
  - `max_epoch=0`: `done` at cycle 2, reason 01, no `req`.
  - `n_train=0`, `n_valid=3`: only `train_mode=0` requests.
  - Validation errors of 0xFFFF with `ACC=16`: accumulator saturates at 0xFFFF.
- Reset: deassert and reassert `rst_n` during V_WAIT.
  - Required: all outputs return to their reset values asynchronously; the scheduler idles until `start`.

Source files
------------

// File: rtl/train_scheduler_if.sv
// Host/datapath bundle for train_scheduler: configuration, sample request/completion and run status.
interface train_scheduler_if #(
  parameter int unsigned BITS = 16
);
  logic            start;
  logic            abort;
  logic [BITS-1:0] n_train;
  logic [BITS-1:0] n_valid;
  logic [BITS-1:0] max_epoch;
  logic [BITS-1:0] patience;
  logic            req;
  logic            train_mode;
  logic [BITS-1:0] sample_idx;
  logic [BITS-1:0] epoch;
  logic            done_in;
  logic [BITS-1:0] sample_err;
  logic            save;
  logic            busy;
  logic            done;
  logic [1:0]      stop_reason;

  modport master (
    output start, abort, n_train, n_valid, max_epoch, patience, done_in, sample_err,
    input  req, train_mode, sample_idx, epoch, save, busy, done, stop_reason
  );

  modport slave (
    input  start, abort, n_train, n_valid, max_epoch, patience, done_in, sample_err,
    output req, train_mode, sample_idx, epoch, save, busy, done, stop_reason
  );
endinterface

// File: rtl/train_scheduler.sv
// Epoch sequencer: issues training then validation sample requests, tracks best validation
// error per epoch, pulses save on improvement and stops on max epoch, patience or abort.
module train_scheduler #(
  parameter int unsigned BITS = 16,
  parameter int unsigned ACC  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  train_scheduler_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_T_REQ, S_T_WAIT, S_V_REQ, S_V_WAIT, S_EVAL, S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_entry;
  logic [BITS-1:0] r_n_train, r_n_valid, r_max_epoch, r_patience;
  logic [BITS-1:0] r_sample_idx, r_epoch, r_stall;
  logic [ACC-1:0]  r_acc, r_best;
  logic            r_req, r_train_mode, r_save, r_busy, r_done;
  logic [1:0]      r_stop_reason;

  logic [BITS-1:0] w_nt, w_nv, w_stall_next;
  logic [ACC:0]    w_sum;
  logic [ACC-1:0]  w_acc_next;
  logic            w_improved, w_last_epoch, w_t_last, w_v_last;

  always_comb begin
    w_nt         = (r_state == S_IDLE) ? bus.n_train : r_n_train;
    w_nv         = (r_state == S_IDLE) ? bus.n_valid : r_n_valid;
    w_entry      = (w_nt != '0) ? S_T_REQ : ((w_nv != '0) ? S_V_REQ : S_EVAL);
    w_sum        = {1'b0, r_acc} + {{(ACC + 1 - BITS){1'b0}}, bus.sample_err};
    w_acc_next   = w_sum[ACC] ? '1 : w_sum[ACC-1:0];
    w_improved   = (r_epoch == '0) || (r_acc < r_best);
    w_stall_next = w_improved ? '0 : r_stall + BITS'(1);
    w_last_epoch = ({1'b0, r_epoch} + {{BITS{1'b0}}, 1'b1}) == {1'b0, r_max_epoch};
    w_t_last     = r_sample_idx == r_n_train - BITS'(1);
    w_v_last     = r_sample_idx == r_n_valid - BITS'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_n_train     <= '0;
      r_n_valid     <= '0;
      r_max_epoch   <= '0;
      r_patience    <= '0;
      r_sample_idx  <= '0;
      r_epoch       <= '0;
      r_stall       <= '0;
      r_acc         <= '0;
      r_best        <= '1;
      r_req         <= 1'b0;
      r_train_mode  <= 1'b0;
      r_save        <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_stop_reason <= 2'b00;
    end else begin
      r_req  <= 1'b0;
      r_save <= 1'b0;
      // Abort wins over any same-cycle completion; a run already in DONE just finishes.
      if (r_busy && bus.abort && r_state != S_DONE) begin
        r_state       <= S_DONE;
        r_done        <= 1'b1;
        r_stop_reason <= 2'b11;
      end else begin
        case (r_state)
          S_IDLE: if (bus.start) begin
            r_n_train    <= bus.n_train;
            r_n_valid    <= bus.n_valid;
            r_max_epoch  <= bus.max_epoch;
            r_patience   <= bus.patience;
            r_epoch      <= '0;
            r_sample_idx <= '0;
            r_stall      <= '0;
            r_acc        <= '0;
            r_busy       <= 1'b1;
            if (bus.max_epoch == '0) begin
              r_state       <= S_DONE;
              r_stop_reason <= 2'b01;
            end else begin
              r_stop_reason <= 2'b00;
              r_state       <= w_entry;
              r_req         <= (w_entry != S_EVAL);
              r_train_mode  <= (w_entry == S_T_REQ);
            end
          end
          S_T_REQ: r_state <= S_T_WAIT;
          S_T_WAIT: if (bus.done_in) begin
            if (w_t_last) begin
              r_sample_idx <= '0;
              if (r_n_valid == '0) begin
                r_state <= S_EVAL;
              end else begin
                r_state      <= S_V_REQ;
                r_req        <= 1'b1;
                r_train_mode <= 1'b0;
              end
            end else begin
              r_sample_idx <= r_sample_idx + BITS'(1);
              r_state      <= S_T_REQ;
              r_req        <= 1'b1;
            end
          end
          S_V_REQ: r_state <= S_V_WAIT;
          S_V_WAIT: if (bus.done_in) begin
            r_acc <= w_acc_next;
            if (w_v_last) begin
              r_sample_idx <= '0;
              r_state      <= S_EVAL;
            end else begin
              r_sample_idx <= r_sample_idx + BITS'(1);
              r_state      <= S_V_REQ;
              r_req        <= 1'b1;
            end
          end
          S_EVAL: begin
            r_acc   <= '0;
            r_stall <= w_stall_next;
            if (w_improved) begin
              r_best <= r_acc;
              r_save <= 1'b1;
            end
            if (r_patience != '0 && w_stall_next == r_patience) begin
              r_state       <= S_DONE;
              r_done        <= 1'b1;
              r_stop_reason <= 2'b10;
            end else if (w_last_epoch) begin
              r_state       <= S_DONE;
              r_done        <= 1'b1;
              r_stop_reason <= 2'b01;
            end else begin
              r_epoch      <= r_epoch + BITS'(1);
              r_state      <= w_entry;
              r_req        <= (w_entry != S_EVAL);
              r_train_mode <= (w_entry == S_T_REQ);
            end
          end
          S_DONE: begin
            // Entry straight from IDLE (max_epoch==0) spends one busy cycle before pulsing done.
            if (!r_done) begin
              r_done <= 1'b1;
            end else begin
              r_done  <= 1'b0;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.req         = r_req;
  assign bus.train_mode  = r_train_mode;
  assign bus.sample_idx  = r_sample_idx;
  assign bus.epoch       = r_epoch;
  assign bus.save        = r_save;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.stop_reason = r_stop_reason;

endmodule

// File: tb/tb_train_scheduler.sv
// Scenario bench for train_scheduler: expected requests are queued per run and popped as the DUT issues them.
module tb_train_scheduler;

  typedef struct packed {
    logic [15:0] epoch;
    logic        mode;
    logic [15:0] idx;
  } req_t;

  logic clk;
  logic rst_n;

  train_scheduler_if #(.BITS(16)) bus ();

  train_scheduler #(.BITS(16), .ACC(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  req_t        sb[$];
  logic [15:0] save_mask;
  logic [15:0] err_e0, err_rest;
  logic [1:0]  done_reason, reason_c1;
  logic        busy_c1, req_c1, busy_at_done, busy_after;
  int          req_count, done_cyc, abort_cyc, last_save_cyc, max_ep;

  function automatic void push_epochs(input int ne, input int nt, input int nv);
    req_t r;
    for (int e = 0; e < ne; e++) begin
      for (int i = 0; i < nt; i++) begin
        r.epoch = 16'(e); r.mode = 1'b1; r.idx = 16'(i);
        sb.push_back(r);
      end
      for (int i = 0; i < nv; i++) begin
        r.epoch = 16'(e); r.mode = 1'b0; r.idx = 16'(i);
        sb.push_back(r);
      end
    end
  endfunction

  // Starts a run and plays the datapath (done_in 3 cycles after each req) until done or an early stop point.
  task automatic run(input logic [15:0] nt, input logic [15:0] nv, input logic [15:0] me,
                     input logic [15:0] pt, input int abort_on_resp, input int stop_after);
    int          cyc, cnt, resp;
    bit          fin, stop_next;
    logic [15:0] last_ep;
    req_t        exp;
    save_mask = '0; req_count = 0; done_cyc = -1; abort_cyc = -1; last_save_cyc = -1;
    max_ep = 0; busy_at_done = 1'b0; busy_after = 1'b1; done_reason = 2'b00;
    cnt = 0; resp = 0; fin = 0; stop_next = 0; last_ep = '0;
    bus.n_train = nt; bus.n_valid = nv; bus.max_epoch = me; bus.patience = pt;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
    reason_c1 = bus.stop_reason; busy_c1 = bus.busy; req_c1 = bus.req;
    while (1) begin
      bus.done_in = 1'b0;
      bus.abort   = 1'b0;
      if (bus.save) begin
        save_mask[last_ep[3:0]] = 1'b1;
        last_save_cyc = cyc;
      end
      if (int'(bus.epoch) > max_ep) max_ep = int'(bus.epoch);
      if (bus.req) begin
        req_count++;
        last_ep = bus.epoch;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL req_unexpected: got epoch=%0d mode=%0b idx=%0d, expected no request",
                   bus.epoch, bus.train_mode, bus.sample_idx);
        end else begin
          exp = sb.pop_front();
          if (bus.epoch !== exp.epoch || bus.train_mode !== exp.mode || bus.sample_idx !== exp.idx) begin
            errors++;
            $display("FAIL req_order: got epoch=%0d mode=%0b idx=%0d, expected epoch=%0d mode=%0b idx=%0d",
                     bus.epoch, bus.train_mode, bus.sample_idx, exp.epoch, exp.mode, exp.idx);
          end
        end
        cnt = 3;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          bus.done_in    = 1'b1;
          bus.sample_err = (last_ep == 16'd0) ? err_e0 : err_rest;
          resp++;
          if (resp == abort_on_resp) begin
            bus.abort = 1'b1;
            abort_cyc = cyc;
          end
        end
      end
      if (fin) begin
        busy_after = bus.busy;
        break;
      end
      if (bus.done) begin
        done_cyc = cyc; done_reason = bus.stop_reason; busy_at_done = bus.busy; fin = 1;
      end
      if (stop_after > 0 && req_count >= stop_after) begin
        if (stop_next) break;
        stop_next = 1;
      end
      if (cyc >= 3000) begin
        checks++; errors++;
        $display("FAIL run_timeout: no done after %0d cycles, required done within budget", cyc);
        break;
      end
      @(negedge clk);
      cyc++;
    end
    bus.done_in = 1'b0;
    bus.abort   = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #20;
    checks++;
    if ({bus.req, bus.train_mode, bus.save, bus.busy, bus.done, bus.sample_idx, bus.epoch, bus.stop_reason} !== 39'h0) begin
      errors++;
      $display("FAIL reset_outputs: got req=%0b tm=%0b save=%0b busy=%0b done=%0b idx=%0d ep=%0d rsn=%0d, required all 0",
               bus.req, bus.train_mode, bus.save, bus.busy, bus.done, bus.sample_idx, bus.epoch, bus.stop_reason);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_normal;
    err_e0 = 16'd2; err_rest = 16'd2;
    sb.delete();
    push_epochs(2, 10, 10);
    run(16'd10, 16'd10, 16'd2, 16'd0, 0, 0);
    checks++;
    if (busy_c1 !== 1'b1 || req_c1 !== 1'b1) begin
      errors++; $display("FAIL normal_first_req: got busy=%0b req=%0b at cycle 1, required 1/1", busy_c1, req_c1);
    end
    checks++;
    if (req_count != 40) begin errors++; $display("FAIL normal_req_count: got %0d, required 40", req_count); end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL normal_missing_reqs: %0d expected requests not issued, required 0", sb.size()); end
    checks++;
    if (save_mask !== 16'h0001) begin errors++; $display("FAIL normal_save: got mask %h, required 0001", save_mask); end
    checks++;
    if (done_reason !== 2'b01) begin errors++; $display("FAIL normal_reason: got %0d, required 1", done_reason); end
    checks++;
    if (busy_at_done !== 1'b1 || busy_after !== 1'b0) begin
      errors++; $display("FAIL normal_busy_end: got busy %0b at done, %0b after, required 1 then 0", busy_at_done, busy_after);
    end
  endtask

  task automatic test_improving;
    err_e0 = 16'd2; err_rest = 16'd1;
    sb.delete();
    push_epochs(2, 10, 10);
    run(16'd10, 16'd10, 16'd2, 16'd0, 0, 0);
    checks++;
    if (save_mask !== 16'h0003) begin errors++; $display("FAIL improving_save: got mask %h, required 0003", save_mask); end
    checks++;
    if (last_save_cyc != done_cyc || done_cyc < 0) begin
      errors++; $display("FAIL improving_save_timing: got save at %0d done at %0d, required same cycle", last_save_cyc, done_cyc);
    end
    checks++;
    if (done_reason !== 2'b01) begin errors++; $display("FAIL improving_reason: got %0d, required 1", done_reason); end
  endtask

  task automatic test_early_stop;
    err_e0 = 16'd4; err_rest = 16'd4;
    sb.delete();
    push_epochs(3, 2, 2);
    run(16'd2, 16'd2, 16'd10, 16'd2, 0, 0);
    checks++;
    if (save_mask !== 16'h0001) begin errors++; $display("FAIL early_save: got mask %h, required 0001", save_mask); end
    checks++;
    if (done_reason !== 2'b10) begin errors++; $display("FAIL early_reason: got %0d, required 2", done_reason); end
    checks++;
    if (max_ep != 2) begin errors++; $display("FAIL early_max_epoch: got %0d, required 2", max_ep); end
    checks++;
    if (sb.size() != 0 || req_count != 12) begin
      errors++; $display("FAIL early_reqs: got %0d reqs, %0d unissued, required 12 and 0", req_count, sb.size());
    end
  endtask

  task automatic test_abort;
    int bad;
    err_e0 = 16'd3; err_rest = 16'd3;
    sb.delete();
    push_epochs(1, 3, 0);
    run(16'd10, 16'd10, 16'd2, 16'd0, 3, 0);
    checks++;
    if (done_cyc != abort_cyc + 1 || abort_cyc < 0) begin
      errors++; $display("FAIL abort_done_timing: got done at %0d abort at %0d, required done one cycle later", done_cyc, abort_cyc);
    end
    checks++;
    if (done_reason !== 2'b11) begin errors++; $display("FAIL abort_reason: got %0d, required 3", done_reason); end
    checks++;
    if (req_count != 3 || save_mask !== 16'h0000) begin
      errors++; $display("FAIL abort_no_more: got %0d reqs save mask %h, required 3 and 0000", req_count, save_mask);
    end
    checks++;
    if (busy_at_done !== 1'b1 || busy_after !== 1'b0) begin
      errors++; $display("FAIL abort_busy: got %0b at done, %0b after, required 1 then 0", busy_at_done, busy_after);
    end
    bad = 0;
    bus.done_in = 1'b1;
    @(negedge clk);
    bus.done_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (bus.req || bus.done || bus.busy || bus.save) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0 || bus.stop_reason !== 2'b11) begin
      errors++; $display("FAIL abort_late_done: got %0d active cycles reason %0d, required 0 and 3", bad, bus.stop_reason);
    end
    err_e0 = 16'd5;
    sb.delete();
    push_epochs(1, 1, 1);
    run(16'd1, 16'd1, 16'd1, 16'd0, 0, 0);
    checks++;
    if (reason_c1 !== 2'b00) begin errors++; $display("FAIL restart_reason_clear: got %0d, required 0", reason_c1); end
    checks++;
    if (done_reason !== 2'b01 || req_count != 2 || save_mask !== 16'h0001) begin
      errors++; $display("FAIL restart_run: got reason %0d reqs %0d save %h, required 1, 2, 0001", done_reason, req_count, save_mask);
    end
  endtask

  task automatic test_max_epoch0;
    sb.delete();
    run(16'd5, 16'd5, 16'd0, 16'd0, 0, 0);
    checks++;
    if (done_cyc != 2) begin errors++; $display("FAIL max0_done_cycle: got %0d, required 2", done_cyc); end
    checks++;
    if (done_reason !== 2'b01 || req_count != 0) begin
      errors++; $display("FAIL max0_result: got reason %0d reqs %0d, required 1 and 0", done_reason, req_count);
    end
  endtask

  task automatic test_no_train;
    err_e0 = 16'd1; err_rest = 16'd1;
    sb.delete();
    push_epochs(1, 0, 3);
    run(16'd0, 16'd3, 16'd1, 16'd0, 0, 0);
    checks++;
    if (req_count != 3 || sb.size() != 0 || done_reason !== 2'b01) begin
      errors++; $display("FAIL no_train: got %0d reqs %0d unissued reason %0d, required 3, 0, 1", req_count, sb.size(), done_reason);
    end
  endtask

  task automatic test_saturation;
    err_e0 = 16'hFFFF; err_rest = 16'h7FFF;
    sb.delete();
    push_epochs(2, 1, 2);
    run(16'd1, 16'd2, 16'd2, 16'd0, 0, 0);
    checks++;
    if (save_mask !== 16'h0003) begin errors++; $display("FAIL saturation_save: got mask %h, required 0003", save_mask); end
  endtask

  task automatic test_reset_midrun;
    int bad;
    err_e0 = 16'd2; err_rest = 16'd2;
    sb.delete();
    push_epochs(1, 2, 1);
    run(16'd2, 16'd3, 16'd2, 16'd0, 0, 3);
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL midrun_busy: got %0b before reset, required 1", bus.busy); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.req, bus.train_mode, bus.save, bus.busy, bus.done, bus.sample_idx, bus.epoch, bus.stop_reason} !== 39'h0) begin
      errors++;
      $display("FAIL midrun_reset_outputs: got tm=%0b busy=%0b idx=%0d ep=%0d rsn=%0d, required all 0",
               bus.train_mode, bus.busy, bus.sample_idx, bus.epoch, bus.stop_reason);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.req || bus.done || bus.busy || bus.save) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL midrun_idle: got %0d active cycles after reset, required 0", bad); end
  endtask

  initial begin
    rst_n = 1'b1;
    bus.start = 1'b0; bus.abort = 1'b0; bus.done_in = 1'b0; bus.sample_err = '0;
    bus.n_train = '0; bus.n_valid = '0; bus.max_epoch = '0; bus.patience = '0;
    err_e0 = '0; err_rest = '0;
    test_reset;
    test_normal;
    test_improving;
    test_early_stop;
    test_abort;
    test_max_epoch0;
    test_no_train;
    test_saturation;
    test_reset_midrun;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
